// File: rtl/m_bist_pkg.sv
// ---------------------------------------------------------------------------
// m_bist_pkg
// Shared definitions for the inverter BIST: the LFSR seed and tap mask, the
// controller state encoding, and a helper that computes the next LFSR value.
// ---------------------------------------------------------------------------
package m_bist_pkg;

   // Every run starts from this seed, so the stimulus sequence is reproducible.
   localparam logic [7:0] LFSR_SEED = 8'h01;

   // Taps at bit positions 8,6,5,4 (1-based), i.e. register bits 7,5,4,3.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   // Fibonacci step: shift towards the MSB and feed the XOR of the tapped
   // bits back into bit 0, which is the bit presented as stimulus.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/m_lfsr8.sv
// ---------------------------------------------------------------------------
// m_lfsr8
// 8-bit Fibonacci LFSR used as the BIST stimulus source.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset, forces the seed
//   load    - synchronous reload with the seed (has priority over en)
//   en      - advance one step
//   out_bit - register bit 0, the current stimulus bit
// ---------------------------------------------------------------------------
module m_lfsr8
   import m_bist_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic out_bit
);

   logic [7:0] lfsr_q;

   // Seed on reset or load so a new run always replays the same sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else if (load) begin
         lfsr_q <= LFSR_SEED;
      end else if (en) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign out_bit = lfsr_q[0];

endmodule

// File: rtl/m_inv_bist.sv
// ---------------------------------------------------------------------------
// m_inv_bist
// Built-in self test for an external inverter. Drives N_VECTORS LFSR bits on
// stim_out, compares resp_in (arriving LAT cycles later) against the
// inverted stimulus, and counts mismatches in a saturating counter.
// Parameters:
//   N_VECTORS - vectors per run (1..65535)
//   LAT       - response latency of the device under test (0..7)
//   ERR_W     - width of err_cnt
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, aborts any run
//   start    - run request, honoured only in IDLE or DONE
//   stim_out - stimulus bit to the inverter, 0 outside RUN
//   resp_in  - response bit from the inverter
//   busy     - high in RUN and DRAIN
//   done     - high in DONE, until the next run starts
//   pass     - high in DONE when no mismatch was seen
//   err_cnt  - mismatches in the current or last run
// ---------------------------------------------------------------------------
module m_inv_bist
   import m_bist_pkg::*;
#(
   parameter int N_VECTORS = 16,
   parameter int LAT       = 0,
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             stim_out,
   input  logic             resp_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [15:0] VEC_LAST   = 16'(N_VECTORS - 1);
   localparam logic [2:0]  DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   bist_state_t state, next_state;
   logic [15:0] vec_cnt;
   logic [2:0]  drain_cnt;
   logic        lfsr_bit;
   logic        start_run;
   logic        in_run;
   logic        cmp_exp;
   logic        cmp_valid;

   // A run may only be launched from IDLE or DONE; start is ignored otherwise.
   assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign in_run    = (state == ST_RUN);

   // Stimulus source: reloaded when a run is launched, stepped once per RUN cycle.
   m_lfsr8 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (start_run),
      .en      (in_run),
      .out_bit (lfsr_bit)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. RUN lasts N_VECTORS cycles, then DRAIN waits LAT
   // cycles for the last responses; with no latency DRAIN is skipped.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (vec_cnt == VEC_LAST) begin
               next_state = (LAT == 0) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               next_state = ST_DONE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Output decode. Stimulus is only exposed during RUN.
   always_comb begin
      stim_out = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      pass     = 1'b0;
      case (state)
         ST_RUN: begin
            stim_out = lfsr_bit;
            busy     = 1'b1;
         end
         ST_DRAIN: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
            pass = (err_cnt == '0);
         end
         default: ;
      endcase
   end

   // Vector and drain counters. The drain counter sits at zero outside
   // DRAIN so it is ready the moment DRAIN is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         if (start_run) begin
            vec_cnt <= '0;
         end else if (in_run) begin
            vec_cnt <= vec_cnt + 16'd1;
         end
         if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + 3'd1;
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // Expected-response alignment. The expected bit travels with a valid
   // flag so that only genuine vectors are ever compared; with LAT=0 the
   // comparison is made against the live stimulus.
   generate
      if (LAT == 0) begin : g_no_lat
         assign cmp_exp   = ~stim_out;
         assign cmp_valid = in_run;
      end else begin : g_lat
         logic [LAT-1:0] exp_pipe;
         logic [LAT-1:0] vld_pipe;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               exp_pipe <= '0;
               vld_pipe <= '0;
            end else if (start_run) begin
               exp_pipe <= '0;
               vld_pipe <= '0;
            end else begin
               exp_pipe[0] <= ~stim_out;
               vld_pipe[0] <= in_run;
               for (int i = 1; i < LAT; i++) begin
                  exp_pipe[i] <= exp_pipe[i-1];
                  vld_pipe[i] <= vld_pipe[i-1];
               end
            end
         end

         assign cmp_exp   = exp_pipe[LAT-1];
         assign cmp_valid = vld_pipe[LAT-1];
      end
   endgenerate

   // Mismatch counter, cleared at launch and saturating at its maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (start_run) begin
         err_cnt <= '0;
      end else if (cmp_valid && (resp_in != cmp_exp) && (err_cnt != ERR_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_m_inv_bist.sv
// ---------------------------------------------------------------------------
// tb_m_inv_bist
// Three BIST instances (16 vectors/LAT 0, 16 vectors/LAT 2, 300 vectors/LAT 0)
// exercised by directed runs with randomised response faults. The bench
// plays the inverter itself and predicts stimulus, busy/done timing and the
// saturated error count from its own reference sequence.
// ---------------------------------------------------------------------------
module tb_m_inv_bist;

   logic       clk;
   logic       rst;
   logic       start_v [3];
   logic       resp_v  [3];
   logic       stim_v  [3];
   logic       busy_v  [3];
   logic       done_v  [3];
   logic       pass_v  [3];
   logic [7:0] err_v   [3];

   int vectors;
   int miscompares;
   logic seq_bits [300];

   m_inv_bist #(.N_VECTORS(16), .LAT(0), .ERR_W(8)) dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .stim_out(stim_v[0]), .resp_in(resp_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]));

   m_inv_bist #(.N_VECTORS(16), .LAT(2), .ERR_W(8)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .stim_out(stim_v[1]), .resp_in(resp_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]));

   m_inv_bist #(.N_VECTORS(300), .LAT(0), .ERR_W(8)) dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .stim_out(stim_v[2]), .resp_in(resp_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Reference stimulus: the maximal-length sequence for x^8+x^6+x^5+x^4+1
   // starting from 1, taking the low bit as each vector.
   task automatic buildSequence();
      int s;
      int fb;
      s = 1;
      for (int i = 0; i < 300; i++) begin
         seq_bits[i] = 1'(s % 2);
         fb = ((s / 128) + (s / 32) + (s / 16) + (s / 8)) % 2;
         s = ((s * 2) + fb) % 256;
      end
   endtask

   // One run on instance d. mode 0: healthy inverter, 1: buffer fault,
   // 2: healthy inverter with random flipped responses. start_at injects a
   // start pulse in that cycle; rst_at aborts the run in that cycle.
   task automatic applyStimulus(input int d, input int n, input int lat, input int mode,
                                input int start_at, input int rst_at);
      int   exp_err;
      int   k;
      logic good;
      logic r;
      exp_err = 0;
      @(negedge clk);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      for (int c = 0; c <= n + lat; c++) begin
         checkOutput($sformatf("busy d%0d c%0d", d, c), int'(busy_v[d]), int'(c < n + lat));
         checkOutput($sformatf("done d%0d c%0d", d, c), int'(done_v[d]), int'(c == n + lat));
         checkOutput($sformatf("stim d%0d c%0d", d, c), int'(stim_v[d]),
                     (c < n) ? int'(seq_bits[c]) : 0);
         checkOutput($sformatf("err d%0d c%0d", d, c), int'(err_v[d]),
                     (exp_err > 255) ? 255 : exp_err);
         checkOutput($sformatf("pass d%0d c%0d", d, c), int'(pass_v[d]),
                     int'((c == n + lat) && (exp_err == 0)));
         if (c == n + lat) break;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            checkOutput($sformatf("rst stim d%0d", d), int'(stim_v[d]), 0);
            checkOutput($sformatf("rst busy d%0d", d), int'(busy_v[d]), 0);
            checkOutput($sformatf("rst done d%0d", d), int'(done_v[d]), 0);
            checkOutput($sformatf("rst pass d%0d", d), int'(pass_v[d]), 0);
            checkOutput($sformatf("rst err d%0d", d), int'(err_v[d]), 0);
            @(negedge clk);
            rst = 1'b0;
            for (int j = 0; j < 24; j++) begin
               checkOutput($sformatf("abort busy d%0d j%0d", d, j), int'(busy_v[d]), 0);
               checkOutput($sformatf("abort done d%0d j%0d", d, j), int'(done_v[d]), 0);
               resp_v[d] = 1'($urandom);
               @(negedge clk);
            end
            return;
         end
         start_v[d] = (c == start_at);
         k = c - lat;
         if (k >= 0 && k < n) begin
            good = ~seq_bits[k];
            if (mode == 1) begin
               r = seq_bits[k];
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
               r = ~good;
            end else begin
               r = good;
            end
            if (r != good) exp_err++;
         end else begin
            r = 1'($urandom);
         end
         resp_v[d] = r;
         @(negedge clk);
      end
      start_v[d] = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         resp_v[i]  = 1'b0;
      end
      buildSequence();

      // Reset state of every instance.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset stim d%0d", i), int'(stim_v[i]), 0);
         checkOutput($sformatf("reset busy d%0d", i), int'(busy_v[i]), 0);
         checkOutput($sformatf("reset done d%0d", i), int'(done_v[i]), 0);
         checkOutput($sformatf("reset pass d%0d", i), int'(pass_v[i]), 0);
         checkOutput($sformatf("reset err d%0d", i), int'(err_v[i]), 0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] LAT=0 healthy inverter");
      applyStimulus(0, 16, 0, 0, -1, -1);
      $display("[TB] LAT=0 random faults, stray start in cycle 5");
      applyStimulus(0, 16, 0, 2, 5, -1);
      $display("[TB] restart from DONE, healthy inverter");
      applyStimulus(0, 16, 0, 0, -1, -1);
      $display("[TB] LAT=0 buffer fault");
      applyStimulus(0, 16, 0, 1, -1, -1);
      $display("[TB] LAT=2 healthy inverter");
      applyStimulus(1, 16, 2, 0, -1, -1);
      $display("[TB] LAT=2 random faults");
      applyStimulus(1, 16, 2, 2, -1, -1);
      $display("[TB] LAT=2 buffer fault");
      applyStimulus(1, 16, 2, 1, -1, -1);
      $display("[TB] 300 vectors, buffer fault, counter saturation");
      applyStimulus(2, 300, 0, 1, -1, -1);
      $display("[TB] 300 vectors, random faults");
      applyStimulus(2, 300, 0, 2, -1, -1);
      $display("[TB] reset abort in cycle 7");
      applyStimulus(0, 16, 0, 0, -1, 7);
      $display("[TB] fresh run after abort");
      applyStimulus(0, 16, 0, 2, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
